// File: rtl/limn2600_bus_pkg.sv
// Shared definitions for the Limn2600 SRAM word-bus initiator.
// Holds the request size encodings, the initiator state type, the bus address
// width and the request legality check.
package limn2600_bus_pkg;

  localparam int unsigned MEM_ADDR_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StDrain,
    StResp
  } bus_state_e;

  // Misaligned half/word or the reserved size: answered without a bus cycle.
  function automatic logic req_error(logic [1:0] size, logic [1:0] lane);
    logic err;
    err = 1'b0;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = lane[0];
      SIZE_WORD: err = |lane;
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/limn2600_lane_merge.sv
// Little-endian byte-lane steering between a 32-bit SRAM word and a core access.
// Ports:
//   word_i    - word as read from the SRAM
//   lane_i    - byte address bits [1:0]
//   size_i    - access size (SIZE_BYTE/HALF/WORD)
//   wdata_i   - right-aligned store data
//   merged_o  - word with the addressed lane(s) replaced by wdata_i
//   extract_o - addressed lane(s) of word_i, zero-extended and right-aligned
module limn2600_lane_merge
  import limn2600_bus_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] extract_o
);

  always_comb begin
    merged_o  = word_i;
    extract_o = word_i;
    case (size_i)
      SIZE_BYTE: begin
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        extract_o = {24'h0, word_i[{lane_i, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        extract_o = {16'h0, word_i[{lane_i[1], 4'b0000} +: 16]};
      end
      default: begin
        merged_o  = wdata_i;
        extract_o = word_i;
      end
    endcase
  end

endmodule

// File: rtl/limn2600_bus_initiator.sv
// CPU-side initiator for the Limn2600 SRAM word bus.
// Turns byte/half/word loads and stores into word accesses; sub-word stores are
// a read-modify-write. Every access is followed by a drain phase that waits for
// the responder's level rdy to fall, so a stale rdy never completes the next access.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   req_*                      - core request (valid/ready handshake)
//   rsp_valid_o/rdata_o/err_o  - one-cycle response pulse, no backpressure
//   mem_*                      - SRAM word bus (cs/we/addr/wdata/rdata/rdy)
module limn2600_bus_initiator
  import limn2600_bus_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic [31:0]           req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rdy_i
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  bus_state_e            state_q;
  logic                  we_q;
  logic [1:0]            size_q;
  logic [1:0]            lane_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  rd_done_q;  // read half of an RMW finished, write still owed
  logic                  err_q;
  logic [7:0]            tmo_cnt_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  mem_cs_q;
  logic                  mem_we_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  logic [31:0] merged;
  logic [31:0] extract;

  limn2600_lane_merge u_lane_merge (
    .word_i    (buf_q),
    .lane_i    (lane_q),
    .size_i    (size_q),
    .wdata_i   (wdata_q),
    .merged_o  (merged),
    .extract_o (extract)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      lane_q      <= 2'b00;
      wdata_q     <= '0;
      buf_q       <= '0;
      rd_done_q   <= 1'b0;
      err_q       <= 1'b0;
      tmo_cnt_q   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            we_q      <= req_we_i;
            size_q    <= req_size_i;
            lane_q    <= req_addr_i[1:0];
            wdata_q   <= req_wdata_i;
            rd_done_q <= 1'b0;
            err_q     <= 1'b0;
            tmo_cnt_q <= 8'h00;
            if (req_error(req_size_i, req_addr_i[1:0])) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              mem_cs_q   <= 1'b1;
              mem_addr_q <= {req_addr_i[31:2], 2'b00};
              if (req_we_i && (req_size_i == SIZE_WORD)) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= req_wdata_i;
                state_q     <= StWrite;
              end else begin
                mem_we_q <= 1'b0;
                state_q  <= StRead;
              end
            end
          end
        end
        StRead, StWrite: begin
          if (mem_rdy_i) begin
            if (state_q == StRead) begin
              buf_q     <= mem_rdata_i;
              rd_done_q <= 1'b1;
            end
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= StDrain;
          end else if (tmo_cnt_q == TimeoutLast) begin
            err_q    <= 1'b1;
            mem_cs_q <= 1'b0;
            mem_we_q <= 1'b0;
            state_q  <= StDrain;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'h01;
          end
        end
        StDrain: begin
          if (!mem_rdy_i) begin
            // rd_done_q is only ever set for a sub-word store's read or a load.
            if (!err_q && we_q && rd_done_q) begin
              rd_done_q   <= 1'b0;
              tmo_cnt_q   <= 8'h00;
              mem_cs_q    <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merged;
              state_q     <= StWrite;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= err_q;
              rsp_rdata_q <= (!we_q && !err_q) ? extract : '0;
              state_q     <= StResp;
            end
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_cs_o    = mem_cs_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
